// File: rtl/scratchpad_ctrl.sv
// Block-level scratchpad controller: splits BLOCK_BITS reads/writes into SRAM beats.
// Define SCRATCHPAD_FWD_EN to add a last-write forward register that serves matching reads.
module scratchpad_ctrl #(
    parameter int BLOCK_BITS        = 1024,
    parameter int SRAM_DATA_BITS    = 256,
    parameter int BLOCK_ADDR_BITS   = 10,
    parameter int NUM_BLOCKS        = 1024,
    parameter int SRAM_READ_LATENCY = 1,
    localparam int BEATS            = BLOCK_BITS / SRAM_DATA_BITS,
    localparam int BEAT_BITS        = $clog2(BEATS),
    localparam int SRAM_ADDR_BITS   = BLOCK_ADDR_BITS + BEAT_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_read,
    input  logic                       req_write,
    input  logic [BLOCK_ADDR_BITS-1:0] req_addr,
    input  logic [BLOCK_BITS-1:0]      req_wdata,
    output logic                       req_ready,
    output logic                       rsp_valid,
    output logic [BLOCK_BITS-1:0]      rsp_rdata,
    output logic                       err,
    output logic                       sram_r_enable,
    output logic                       sram_w_enable,
    output logic [SRAM_ADDR_BITS-1:0]  sram_addr,
    output logic [SRAM_DATA_BITS-1:0]  sram_w_data,
    input  logic [SRAM_DATA_BITS-1:0]  sram_r_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_ISSUE,
        S_READ_WAIT,
        S_FWD
    } state_t;

    localparam logic [BEAT_BITS-1:0]     LAST_BEAT    = BEAT_BITS'(BEATS - 1);
    localparam logic [BLOCK_ADDR_BITS:0] NUM_BLOCKS_W = (BLOCK_ADDR_BITS + 1)'(NUM_BLOCKS);

    state_t                         state_q, state_d;
    logic [BEAT_BITS-1:0]           beat_q, beat_d;
    logic [BEAT_BITS-1:0]           cap_q, cap_d;
    logic [SRAM_READ_LATENCY-1:0]   vld_pipe_q, vld_pipe_d;
    logic [BLOCK_ADDR_BITS-1:0]     blk_q, blk_d;
    logic [BLOCK_BITS-1:0]          wdata_q, wdata_d;
    logic [BLOCK_BITS-1:0]          rbuf_q, rbuf_d;
    logic [BLOCK_BITS-1:0]          rsp_rdata_q, rsp_rdata_d;
    logic                           rsp_valid_q, rsp_valid_d;
    logic                           err_q, err_d;

    logic addr_ok, accept_wr, accept_rd, illegal;
    logic beat_last, cap_fire, cap_last, fwd_hit;

`ifdef SCRATCHPAD_FWD_EN
    logic                       fwd_vld_q, fwd_vld_d;
    logic [BLOCK_ADDR_BITS-1:0] fwd_addr_q, fwd_addr_d;
    logic [BLOCK_BITS-1:0]      fwd_data_q, fwd_data_d;

    assign fwd_hit = fwd_vld_q && (fwd_addr_q == req_addr);
`else
    assign fwd_hit = 1'b0;
`endif

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign addr_ok   = {1'b0, req_addr} < NUM_BLOCKS_W;
    assign accept_wr = req_ready && req_write && !req_read && addr_ok;
    assign accept_rd = req_ready && req_read && !req_write && addr_ok;
    assign illegal   = req_ready && (req_read || req_write) && ((req_read && req_write) || !addr_ok);
    assign beat_last = (beat_q == LAST_BEAT);
    // vld_pipe tracks issued read beats until their data is on sram_r_data
    assign cap_fire  = vld_pipe_q[SRAM_READ_LATENCY-1];
    assign cap_last  = cap_fire && (cap_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_wr) begin
                    state_d = S_WRITE;
                end else if (accept_rd) begin
                    state_d = fwd_hit ? S_FWD : S_READ_ISSUE;
                end
            end
            S_WRITE:      if (beat_last) state_d = S_IDLE;
            S_READ_ISSUE: if (beat_last) state_d = S_READ_WAIT;
            S_READ_WAIT:  if (cap_last)  state_d = S_IDLE;
            S_FWD:        state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sram_w_enable = (state_q == S_WRITE);
        sram_r_enable = (state_q == S_READ_ISSUE);
        sram_addr     = {blk_q, beat_q};
        sram_w_data   = wdata_q[beat_q * SRAM_DATA_BITS +: SRAM_DATA_BITS];
    end

    always_comb begin
        beat_d      = beat_q;
        cap_d       = cap_q;
        blk_d       = blk_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = 1'b0;
        err_d       = illegal;
        vld_pipe_d  = '0;
        vld_pipe_d[0] = sram_r_enable;
        for (int i = 1; i < SRAM_READ_LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
`ifdef SCRATCHPAD_FWD_EN
        fwd_vld_d  = fwd_vld_q;
        fwd_addr_d = fwd_addr_q;
        fwd_data_d = fwd_data_q;
`endif

        if (accept_wr || accept_rd) begin
            blk_d  = req_addr;
            beat_d = '0;
        end
        if (accept_wr) begin
            wdata_d = req_wdata;
        end
        if ((state_q == S_WRITE) || (state_q == S_READ_ISSUE)) begin
            beat_d = beat_last ? '0 : beat_q + 1'b1;
        end
        if (cap_fire) begin
            rbuf_d[cap_q * SRAM_DATA_BITS +: SRAM_DATA_BITS] = sram_r_data;
            cap_d = cap_last ? '0 : cap_q + 1'b1;
        end
        if ((state_q == S_WRITE) && beat_last) begin
            rsp_valid_d = 1'b1;
`ifdef SCRATCHPAD_FWD_EN
            fwd_vld_d  = 1'b1;
            fwd_addr_d = blk_q;
            fwd_data_d = wdata_q;
`endif
        end
        // the final beat goes straight from sram_r_data into the response
        if ((state_q == S_READ_WAIT) && cap_last) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rbuf_d;
        end
`ifdef SCRATCHPAD_FWD_EN
        if (state_q == S_FWD) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = fwd_data_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q      <= '0;
            cap_q       <= '0;
            vld_pipe_q  <= '0;
            blk_q       <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            beat_q      <= beat_d;
            cap_q       <= cap_d;
            vld_pipe_q  <= vld_pipe_d;
            blk_q       <= blk_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
        end
    end

`ifdef SCRATCHPAD_FWD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_vld_q  <= 1'b0;
            fwd_addr_q <= '0;
            fwd_data_q <= '0;
        end else begin
            fwd_vld_q  <= fwd_vld_d;
            fwd_addr_q <= fwd_addr_d;
            fwd_data_q <= fwd_data_d;
        end
    end
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_scratchpad_ctrl.sv
// Scoreboard bench for scratchpad_ctrl: driver pushes expected responses and SRAM beats,
// a negedge monitor pops and compares them against a beat-level SRAM model.
module tb_scratchpad_ctrl;
    localparam int NB = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_read, req_write;
    logic [9:0]    req_addr;
    logic [1023:0] req_wdata;
    logic          req_ready, rsp_valid, err;
    logic [1023:0] rsp_rdata;
    logic          sram_r_enable, sram_w_enable;
    logic [11:0]   sram_addr;
    logic [255:0]  sram_w_data, sram_r_data;

    always #5 clk = ~clk;

    scratchpad_ctrl #(.NUM_BLOCKS(NB)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
        .sram_r_enable(sram_r_enable), .sram_w_enable(sram_w_enable),
        .sram_addr(sram_addr), .sram_w_data(sram_w_data), .sram_r_data(sram_r_data)
    );

    typedef struct {
        bit            is_err;
        bit            is_rd;
        logic [1023:0] data;
        int            acc;
        int            lat;
    } rsp_exp_t;

    typedef struct {
        bit            we;
        logic [11:0]   addr;
        logic [255:0]  data;
    } sram_exp_t;

    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    int            last_acc = 0;
    rsp_exp_t      rq[$];
    sram_exp_t     sq[$];
    logic [1023:0] shadow [int];
    bit            tb_fwd_v = 1'b0;
    int            tb_fwd_a = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // unwritten SRAM words hold a recognisable pattern derived from their address
    function automatic logic [255:0] pat(input logic [11:0] sa);
        return {16{4'hA, sa}};
    endfunction

    function automatic logic [1023:0] exp_block(input int b);
        logic [1023:0] r;
        if (shadow.exists(b)) return shadow[b];
        for (int k = 0; k < 4; k++) r[k*256 +: 256] = pat({b[9:0], 2'(k)});
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [255:0] mem [4096];
    bit           wr_flag [4096];
    always @(posedge clk) begin
        if (sram_w_enable) begin
            mem[sram_addr]     <= sram_w_data;
            wr_flag[sram_addr] <= 1'b1;
        end
        if (sram_r_enable) sram_r_data <= wr_flag[sram_addr] ? mem[sram_addr] : pat(sram_addr);
    end

    initial begin
        rsp_exp_t  e;
        sram_exp_t s;
        forever begin
            @(negedge clk);
            if (rsp_valid || err) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rsp", {254'd0, rsp_valid, err}, 256'd0);
                end else begin
                    e = rq.pop_front();
                    chk("rsp_err", err, e.is_err);
                    chk("rsp_valid", rsp_valid, !e.is_err);
                    chk("latency", cyc - e.acc + 1, e.lat);
                    if (e.is_rd)
                        for (int k = 0; k < 4; k++)
                            chk($sformatf("rdata_b%0d", k), rsp_rdata[k*256 +: 256], e.data[k*256 +: 256]);
                end
            end
            chk("both_strobes", sram_r_enable & sram_w_enable, 256'd0);
            if (sram_r_enable || sram_w_enable) begin
                if (sq.size() == 0) begin
                    chk("unexpected_sram", {254'd0, sram_r_enable, sram_w_enable}, 256'd0);
                end else begin
                    s = sq.pop_front();
                    chk("sram_we", sram_w_enable, s.we);
                    chk("sram_addr", sram_addr, s.addr);
                    if (s.we) chk("sram_wdata", sram_w_data, s.data);
                end
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input int addr, input logic [1023:0] wd, input bit bad);
        int        t;
        bit        hit;
        rsp_exp_t  e;
        sram_exp_t s;
        @(negedge clk);
        req_read = rd; req_write = wr; req_addr = 10'(addr); req_wdata = wd;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", req_ready, 256'd1);
        @(posedge clk);
        #1;
        last_acc = cyc;
        req_read = 1'b0; req_write = 1'b0;
        e.acc = cyc; e.is_err = bad; e.is_rd = rd && !bad; e.data = '0; e.lat = 1;
        if (!bad && wr) begin
            for (int k = 0; k < 4; k++) begin
                s.we = 1'b1; s.addr = {10'(addr), 2'(k)}; s.data = wd[k*256 +: 256];
                sq.push_back(s);
            end
            e.lat = 5;
            shadow[addr] = wd;
            tb_fwd_v = 1'b1; tb_fwd_a = addr;
        end else if (!bad) begin
            e.data = exp_block(addr);
            hit = 1'b0;
`ifdef SCRATCHPAD_FWD_EN
            hit = tb_fwd_v && (tb_fwd_a == addr);
`endif
            if (hit) begin
                e.lat = 2;
            end else begin
                e.lat = 6;
                for (int k = 0; k < 4; k++) begin
                    s.we = 1'b0; s.addr = {10'(addr), 2'(k)}; s.data = '0;
                    sq.push_back(s);
                end
            end
        end
        rq.push_back(e);
    endtask

    initial begin
        int t;
        int prev;
        int addrs[6] = '{0, 2, 4, 8, 16, 64};
        logic [1023:0] held;
        req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        prev = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 256'd0);
        chk("rst_rsp_valid", rsp_valid, 256'd0);
        chk("rst_err", err, 256'd0);
        chk("rst_rdata", rsp_rdata[255:0], 256'd0);
        chk("rst_strobes", {sram_r_enable, sram_w_enable}, 256'd0);
        chk("rst_sram_addr", sram_addr, 256'd0);
        chk("rst_sram_wdata", sram_w_data, 256'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 256'd1);

        issue(0, 1, 3, '1, 0);
        issue(1, 0, 3, '0, 0);
        issue(0, 1, 8, 1024'd5, 0);
        issue(1, 0, 8, '0, 0);

        issue(1, 1, 16, '0, 1);
        @(negedge clk);
        chk("ready_after_err", req_ready, 256'd1);
        issue(1, 0, 1000, '0, 1);
        issue(0, 1, 1023, '0, 1);
        issue(1, 0, 999, '0, 0);

        // reset lands while beat 2 of this write is on the bus
        issue(0, 1, 1, {4{256'h1234}}, 0);
        void'(rq.pop_back());
        void'(sq.pop_back());
        shadow.delete(1);
        tb_fwd_v = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_strobes", {sram_r_enable, sram_w_enable}, 256'd0);
        chk("abort_rsp_valid", rsp_valid, 256'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", req_ready, 256'd1);
        chk("abort_err", err, 256'd0);
        for (int k = 0; k < 4; k++) chk($sformatf("abort_rdata_b%0d", k), rsp_rdata[k*256 +: 256], 256'd0);

        foreach (addrs[i]) begin
            issue(1, 0, addrs[i], '0, 0);
            if (i > 0) chk("b2b_gap", last_acc - prev, 256'd6);
            prev = last_acc;
        end

        // strobes raised while busy must be ignored; write must leave rsp_rdata alone
        held = exp_block(64);
        issue(0, 1, 20, {4{256'hC0FFEE}}, 0);
        @(negedge clk);
        req_read = 1'b1; req_write = 1'b1; req_addr = '0;
        @(negedge clk);
        req_read = 1'b0; req_write = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("hold_rdata_b%0d", k), rsp_rdata[k*256 +: 256], held[k*256 +: 256]);
        issue(1, 0, 20, '0, 0);

        t = 0;
        while ((rq.size() != 0 || sq.size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rsp_queue_drained", rq.size(), 256'd0);
        chk("sram_queue_drained", sq.size(), 256'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
